line_buffer_ctrl: RTL and testbench

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

---
 rtl/line_buffer_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl
//
// Frame sequencer that sits in front of a sliding-window line buffer. When
// `start` arrives it accepts one IMAGE_WIDTH x IMAGE_HEIGHT frame of pixels
// from upstream and forwards each one to the line buffer with one cycle of
// latency. It then keeps the controller busy for DRAIN_CYCLES cycles so the
// line buffer can flush its last windows, and finally pulses `done`.
//
// Optional feature (macro LB_CTRL_WINDOW_CHECK_EN): counts the window-valid
// strobes returned by the line buffer during the frame and raises `error`
// when the tally differs from EXPECTED_WINDOWS. Without the macro,
// `windowCount` and `error` are tied to 0.
//
// Ports
//   clk            : clock; all state changes on its rising edge
//   resetn         : asynchronous active-low reset
//   start          : one-cycle frame request (honoured only in IDLE)
//   abort          : synchronous cancel of the frame in progress
//   pixIn/pixValid : upstream pixel and its valid
//   pixReady       : high while the controller accepts pixels (FEED)
//   lbDataIn       : pixel presented to the line buffer
//   lbDataValidIn  : valid presented to the line buffer
//   lbDataValidOut : window-valid strobe returned by the line buffer
//   busy           : high in FEED and DRAIN
//   done           : one-cycle completion pulse
//   error          : window-count mismatch flag
//   windowCount    : number of windows seen in the current frame
// ---------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH      = 8,
  parameter int IMAGE_HEIGHT     = 8,
  parameter int FIXED_POINT_SIZE = 16,
  parameter int DRAIN_CYCLES     = 16,
  parameter int EXPECTED_WINDOWS = 36
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [FIXED_POINT_SIZE-1:0] pixIn,
  input  logic                        pixValid,
  output logic                        pixReady,
  output logic [FIXED_POINT_SIZE-1:0] lbDataIn,
  output logic                        lbDataValidIn,
  input  logic                        lbDataValidOut,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [15:0]                 windowCount
);

  localparam int COL_W = $clog2(IMAGE_WIDTH) + 1;
  localparam int ROW_W = $clog2(IMAGE_HEIGHT) + 1;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  // With DRAIN_CYCLES = 0 the last count is 0 as well, so DRAIN still lasts
  // exactly one cycle.
  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [DRN_W-1:0]            drain_q, drain_d;
  logic [FIXED_POINT_SIZE-1:0] lb_data_q, lb_data_d;
  logic                        lb_valid_q, lb_valid_d;
  logic                        accept;

  // Abort has priority over a pixel offered in the same cycle.
  assign accept = (state_q == S_FEED) && pixValid && !abort;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    drain_d    = drain_q;
    lb_data_d  = lb_data_q;
    lb_valid_d = 1'b0;

    if (accept) begin
      lb_data_d  = pixIn;
      lb_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FEED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pixValid) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q >= DRN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      drain_q    <= '0;
      lb_data_q  <= '0;
      lb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      lb_data_q  <= lb_data_d;
      lb_valid_q <= lb_valid_d;
    end
  end

  // Status outputs are pure decodes of the state register: no input paths.
  assign pixReady      = (state_q == S_FEED);
  assign busy          = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign lbDataIn      = lb_data_q;
  assign lbDataValidIn = lb_valid_q;

`ifdef LB_CTRL_WINDOW_CHECK_EN
  logic [15:0] win_q, win_d;
  logic        err_q, err_d;

  always_comb begin
    win_d = win_q;
    err_d = err_q;
    if ((state_q == S_IDLE) && start) begin
      win_d = '0;
      err_d = 1'b0;
    end else if (busy && lbDataValidOut && (win_q != 16'hFFFF)) begin
      win_d = win_q + 16'd1;
    end else if (state_q == S_DONE) begin
      // The verdict is taken once per frame and then held until the next
      // start, so software can read it at leisure.
      err_d = (win_q != 16'(EXPECTED_WINDOWS));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q <= '0;
      err_q <= 1'b0;
    end else begin
      win_q <= win_d;
      err_q <= err_d;
    end
  end

  assign windowCount = win_q;
  assign error       = err_q;
`else
  logic unused_window_inputs;
  assign unused_window_inputs = ^{lbDataValidOut, 32'(EXPECTED_WINDOWS)};
  assign windowCount          = '0;
  assign error                = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_ctrl
//
// Directed bench for line_buffer_ctrl with default parameters (8x8 frame,
// 16-bit pixels, 16 drain cycles, 36 expected windows). A short table of
// per-cycle vectors covers the basic handshake. Hand-written sequences cover
// whole frames: back-to-back, gapped, aborted, with stray starts, and an
// asynchronous reset in mid-frame. A small line-buffer stand-in returns a
// chosen number of window strobes per frame. Window-check expectations
// follow LB_CTRL_WINDOW_CHECK_EN when it is defined for the bench too.
// ---------------------------------------------------------------------------
module tb_line_buffer_ctrl;

  localparam int NPIX  = 64;
  localparam int DRAIN = 16;
`ifdef LB_CTRL_WINDOW_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] pixIn;
  logic        pixValid;
  logic        pixReady;
  logic [15:0] lbDataIn;
  logic        lbDataValidIn;
  logic        lbDataValidOut = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] windowCount;

  int n_checks = 0;
  int n_fail   = 0;
  int win_target = 36;
  int vin_cnt    = 0;
  logic [15:0] exp_din;

  line_buffer_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .abort         (abort),
    .pixIn         (pixIn),
    .pixValid      (pixValid),
    .pixReady      (pixReady),
    .lbDataIn      (lbDataIn),
    .lbDataValidIn (lbDataValidIn),
    .lbDataValidOut(lbDataValidOut),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .windowCount   (windowCount)
  );

  always #5 clk = ~clk;

  // Line-buffer stand-in: the last win_target pixels of each frame produce a
  // window strobe, driven half a cycle after the pixel reaches it.
  always @(negedge clk) begin
    if (!busy) begin
      vin_cnt        = 0;
      lbDataValidOut = 1'b0;
    end else if (lbDataValidIn) begin
      lbDataValidOut = (vin_cnt >= NPIX - win_target);
      vin_cnt        = vin_cnt + 1;
    end else begin
      lbDataValidOut = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #12;
    resetn = 1'b1;
    step();
    exp_din = '0;
  endtask

  typedef struct {
    logic        st;
    logic        ab;
    logic        pv;
    logic [15:0] px;
    logic        e_rdy;
    logic        e_vin;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_din;
  } vec_t;

  // One frame. abort_after >= 0 cancels the frame (abort together with the
  // next pixel) once pixels 0..abort_after have been accepted.
  task automatic run_frame(input bit toggle, input int abort_after,
                           input bit poke_start, input int target,
                           input bit exp_err);
    int px = 0;
    int guard = 0;
    int drain_busy = 1;
    bit ph = 1'b1;
    bit drive;
    bit ab;
    bit done_seen = 1'b0;

    win_target = target;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", pixReady, 1);
    check("start_err_clr", error, 0);
    check("start_win_clr", windowCount, 0);

    while (px < NPIX && guard < 400) begin
      guard++;
      drive    = toggle ? ph : 1'b1;
      ph       = !ph;
      ab       = (abort_after >= 0) && (px == abort_after + 1) && drive;
      pixValid = drive;
      pixIn    = 16'(px);
      abort    = ab;
      start    = poke_start && (px == 30);
      step();
      start = 1'b0;
      abort = 1'b0;
      if (ab) begin
        pixValid = 1'b0;
        check("abort_ready", pixReady, 0);
        check("abort_busy", busy, 0);
        check("abort_vin", lbDataValidIn, 0);
        check("abort_din_hold", lbDataIn, 32'(exp_din));
        for (int i = 0; i < 25; i++) begin
          step();
          check("abort_no_done", {busy, done, pixReady}, 0);
        end
        return;
      end
      if (drive) begin
        check("feed_vin", lbDataValidIn, 1);
        check("feed_din", lbDataIn, px);
        exp_din = 16'(px);
        px++;
      end else begin
        check("gap_vin", lbDataValidIn, 0);
        check("gap_din_hold", lbDataIn, 32'(exp_din));
      end
    end
    check("feed_guard", guard < 400, 1);
    pixValid = 1'b0;
    check("last_ready_low", pixReady, 0);
    check("last_busy", busy, 1);

    guard = 0;
    while (guard < 100) begin
      guard++;
      start = poke_start && (drain_busy == 5);
      step();
      start = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      check("drain_vin", lbDataValidIn, 0);
      check("drain_ready", pixReady, 0);
      if (busy) drain_busy++;
    end
    check("done_seen", done_seen, 1);
    check("drain_len", drain_busy, DRAIN);
    check("done_busy_low", busy, 0);
    check("done_win", windowCount, CHK ? target : 0);
    step();
    check("done_pulse_1cyc", done, 0);
    check("post_busy", busy, 0);
    check("post_err", error, CHK ? 32'(exp_err) : 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_idle", {busy, done, pixReady}, 0);
    end
  endtask

  initial begin
    vec_t tbl[9];

    start    = 1'b0;
    abort    = 1'b0;
    pixValid = 1'b0;
    pixIn    = '0;
    resetn   = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    check("rst_ready", pixReady, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vin", lbDataValidIn, 0);
    check("rst_din", lbDataIn, 0);
    check("rst_err", error, 0);
    check("rst_win", windowCount, 0);
    #10;
    resetn = 1'b1;
    step();

    //             st ab pv px      rdy vin busy done din
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'd5,  1'b1, 1'b1, 1'b1, 1'b0, 16'd5};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'd6,  1'b1, 1'b0, 1'b1, 1'b0, 16'd5};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'd6,  1'b1, 1'b0, 1'b1, 1'b0, 16'd5};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 16'd7,  1'b1, 1'b1, 1'b1, 1'b0, 16'd7};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'd9,  1'b0, 1'b0, 1'b0, 1'b0, 16'd7};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 16'd11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7};

    for (int i = 0; i < 9; i++) begin
      start    = tbl[i].st;
      abort    = tbl[i].ab;
      pixValid = tbl[i].pv;
      pixIn    = tbl[i].px;
      step();
      check($sformatf("vec%0d_ready", i), pixReady, tbl[i].e_rdy);
      check($sformatf("vec%0d_vin", i), lbDataValidIn, tbl[i].e_vin);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_done", i), done, tbl[i].e_done);
      check($sformatf("vec%0d_din", i), lbDataIn, tbl[i].e_din);
    end
    start    = 1'b0;
    abort    = 1'b0;
    pixValid = 1'b0;

    do_reset();
    run_frame(1'b0, -1, 1'b0, 36, 1'b0);  // back-to-back
    run_frame(1'b1, -1, 1'b0, 35, 1'b1);  // gapped, one window short
    run_frame(1'b0, 20, 1'b0, 36, 1'b0);  // aborted after pixel 20
    run_frame(1'b0, -1, 1'b0, 36, 1'b0);  // clean frame after abort
    run_frame(1'b1, -1, 1'b1, 36, 1'b0);  // stray starts in FEED and DRAIN

    // Asynchronous reset in the middle of FEED.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pixValid = 1'b1;
      pixIn    = 16'(100 + i);
      step();
    end
    check("midrst_pre_busy", busy, 1);
    check("midrst_pre_vin", lbDataValidIn, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_ready", pixReady, 0);
    check("midrst_busy", busy, 0);
    check("midrst_vin", lbDataValidIn, 0);
    check("midrst_din", lbDataIn, 0);
    check("midrst_done_err", {done, error}, 0);
    check("midrst_win", windowCount, 0);
    #3;
    resetn = 1'b1;
    step();
    step();
    check("after_rst_idle", {busy, pixReady, lbDataValidIn}, 0);
    pixValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule
